// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 5..9 data bits LSB first, optional parity,
// 1..2 stop bits, paced by an oversampled baud strobe.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 tx_data,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 bit_end;
    logic                 cnt_bad;

    assign i_ready = (state_q == IDLE) && rst;
    assign tx_data = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

    assign bit_end = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));

    // Counter values no legal frame can reach force a clean return to idle
    always_comb begin
        cnt_bad = int'(tick_q) > OVERSAMPLE - 1;
        unique case (state_q)
            DATA:    cnt_bad = cnt_bad || (int'(bit_q) > DATA_BITS - 1);
            STOP:    cnt_bad = cnt_bad || (int'(bit_q) > STOP_BITS - 1);
            default: cnt_bad = cnt_bad || (bit_q != 4'd0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && baud_tick) begin
                tick_q <= bit_end ? '0 : tick_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    bit_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (i_valid) begin
                        sh_q    <= i_data;
                        par_q   <= (PARITY_ODD != 0) ? ~^i_data : ^i_data;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            state_q <= IDLE;
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
            if (state_q != IDLE && cnt_bad) begin
                state_q <= IDLE;
                tick_q  <= '0;
                bit_q   <= '0;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations share stimulus,
// a monitor samples each bit mid-period and checks completion timing.
module tb_uart_tx_frame;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [8:0] idata;
    logic [3:0] validv;
    logic [3:0] rdyv;
    logic [3:0] txv;
    logic [3:0] busyv;
    logic [3:0] donev;
    logic [1:0] sel;
    logic       txsel;

    int nvec = 0;
    int nmis = 0;
    int donecnt [4] = '{0, 0, 0, 0};

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          b2b;
        bit          abort;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    assign txsel = txv[sel];

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .i_valid(validv[0]), .i_ready(rdyv[0]), .i_data(idata[7:0]),
        .tx_data(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .i_valid(validv[1]), .i_ready(rdyv[1]), .i_data(idata[7:0]),
        .tx_data(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .i_valid(validv[2]), .i_ready(rdyv[2]), .i_data(idata[7:0]),
        .tx_data(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2]));

    uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2), .OVERSAMPLE(OS)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .i_valid(validv[3]), .i_ready(rdyv[3]), .i_data(idata[6:0]),
        .tx_data(txv[3]), .tx_busy(busyv[3]), .tx_done(donev[3]));

    // Irregular strobe pattern: two ticks in a row, then a gap
    initial begin
        int cyc;
        cyc = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            baud_tick = (cyc % 3) != 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (donev[i] === 1'b1) donecnt[i]++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic wait_rdy(input int d);
        int c;
        c = 0;
        @(negedge clk);
        while (rdyv[d] !== 1'b1) begin
            c++;
            if (c > 5000) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send(input int d, input logic [8:0] data,
                        input logic [15:0] bits, input int n,
                        input bit abort, input bit hold);
        exp_t e;
        e.bits  = bits;
        e.n     = n;
        e.b2b   = 1'b0;
        e.abort = abort;
        sel = 2'(d);
        q.push_back(e);
        wait_rdy(d);
        idata     = data;
        validv[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) validv[d] = 1'b0;
    endtask

    // Monitor: pops one expected frame per detected start bit
    initial begin : mon
        exp_t e;
        int   w;
        forever begin
            w = 0;
            @(negedge clk);
            while (txsel !== 1'b0) begin
                w++;
                @(negedge clk);
            end
            if (q.size() == 0) begin
                chk("unexpected_start", 32'd0, 32'd1);
                while (txsel !== 1'b1) @(negedge clk);
            end else begin
                e = q.pop_front();
                if (e.b2b) chk("b2b_gap", w, 32'd1);
                for (int b = 0; b < e.n; b++) begin
                    wait_ticks(OS / 2);
                    #1;
                    chk($sformatf("bit%0d", b), txsel, e.bits[b]);
                    chk("busy", busyv[sel], 1'b1);
                    chk("ready_in_frame", rdyv[sel], 1'b0);
                    wait_ticks(OS / 2);
                end
                #1;
                if (!e.abort) begin
                    chk("done_pulse", donev[sel], 1'b1);
                    chk("ready_after", rdyv[sel], 1'b1);
                end else begin
                    while (txsel !== 1'b1) @(negedge clk);
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        rst    = 1'b0;
        validv = '0;
        idata  = '0;
        sel    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", txv[i], 1'b1);
            chk("rst_busy", busyv[i], 1'b0);
            chk("rst_done", donev[i], 1'b0);
            chk("rst_ready", rdyv[i], 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("ready_post_rst", rdyv[0], 1'b1);

        // 8N1 0x55
        send(0, 9'h055, 16'h02AA, 10, 1'b0, 1'b0);
        wait_rdy(0);
        // 8E1 / 8O1 with 0x07 and 0x00
        send(1, 9'h007, 16'h060E, 11, 1'b0, 1'b0);
        wait_rdy(1);
        send(1, 9'h000, 16'h0400, 11, 1'b0, 1'b0);
        wait_rdy(1);
        send(2, 9'h007, 16'h040E, 11, 1'b0, 1'b0);
        wait_rdy(2);
        send(2, 9'h000, 16'h0600, 11, 1'b0, 1'b0);
        wait_rdy(2);
        // 7N2 0x41
        send(3, 9'h041, 16'h0382, 10, 1'b0, 1'b0);
        wait_rdy(3);

        // Back-to-back 0xA5 then 0x3C with valid held
        send(0, 9'h0A5, 16'h034A, 10, 1'b0, 1'b1);
        idata   = 9'h03C;
        e.bits  = 16'h0278;
        e.n     = 10;
        e.b2b   = 1'b1;
        e.abort = 1'b0;
        q.push_back(e);
        wait_rdy(0);
        @(posedge clk);
        #1;
        validv[0] = 1'b0;
        wait_rdy(0);

        // Mid-frame valid pulse and data change are ignored
        send(0, 9'h096, 16'h032C, 10, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        idata     = 9'h1FF;
        validv[0] = 1'b1;
        #1;
        chk("ready_mid_frame", rdyv[0], 1'b0);
        @(negedge clk);
        validv[0] = 1'b0;
        idata     = 9'h000;
        wait_rdy(0);

        // Reset during data bit 3 aborts the frame
        send(0, 9'h005, 16'h000A, 4, 1'b1, 1'b0);
        wait_ticks(OS * 4 + OS / 2);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", txv[0], 1'b1);
        chk("abort_busy", busyv[0], 1'b0);
        chk("abort_done", donev[0], 1'b0);
        chk("abort_ready", rdyv[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready_rel", rdyv[0], 1'b1);

        send(0, 9'h081, 16'h0302, 10, 1'b0, 1'b0);
        wait_rdy(0);

        repeat (5) @(negedge clk);
        chk("done_count_u0", donecnt[0], 32'd5);
        chk("done_count_u1", donecnt[1], 32'd2);
        chk("done_count_u2", donecnt[2], 32'd2);
        chk("done_count_u3", donecnt[3], 32'd1);
        chk("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
